// File: rtl/div_sequencer.sv
// Iterative unsigned restoring divider for the ALU's DIV/REM opcodes, one quotient bit per cycle.
// Accept to done takes WIDTH+1 cycles (1 cycle for a zero divisor); stall holds the pipeline until done.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [3:0] OP_DIV = 4'b0110;
  localparam logic [3:0] OP_REM = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q, b_q, r;
  logic             is_rem;

  logic             op_ok, accept, last;
  logic [WIDTH:0]   r_sh;
  logic             ge;
  logic [WIDTH-1:0] r_sub, r_nx, q_nx;

  assign op_ok  = (ALUControl == OP_DIV) || (ALUControl == OP_REM);
  assign accept = (state == S_IDLE) && start && op_ok && !flush;
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = (B == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)     state_nx = S_IDLE;
        else if (last) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    stall = accept || (state == S_RUN);
  end

  // The stored remainder is always below the divisor, so its extra top bit only
  // exists transiently in the shifted value used for the compare.
  assign r_sh  = {r, q[WIDTH-1]};
  assign ge    = (r_sh >= {1'b0, b_q});
  assign r_sub = r_sh[WIDTH-1:0] - b_q;
  assign r_nx  = ge ? r_sub : r_sh[WIDTH-1:0];
  assign q_nx  = {q[WIDTH-2:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_rem <= 1'b0;
      b_q    <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      Result <= '0;
    end else if (accept) begin
      is_rem <= (ALUControl == OP_REM);
      b_q    <= B;
      q      <= A;
      r      <= '0;
      cnt    <= '0;
      if (B == '0) Result <= '0;
    end else if ((state == S_RUN) && !flush) begin
      q   <= q_nx;
      r   <= r_nx;
      cnt <= cnt + 1'b1;
      if (last) Result <= is_rem ? r_nx : q_nx;
    end
  end

endmodule
